// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider.
// Contents: default operand width, FSM state encoding, divide-by-zero quotient constant.
package divider_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Quotient reported when the divisor is zero.
  localparam logic [DefaultWidth-1:0] DbzQuot = '1;

endpackage

// File: rtl/div_step.sv
// Single combinational restoring-division step.
// Ports:
//   rem_i     - current partial remainder
//   quot_i    - current quotient shift register (dividend bits still shifting out the top)
//   divisor_i - divisor
//   rem_o     - partial remainder after this step
//   quot_o    - quotient shift register after this step (new quotient bit in the LSB)
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Remainder shifted left with the next dividend bit brought in; one extra bit so the
  // top of the remainder is never lost.
  assign shifted = {rem_i, quot_i[WIDTH-1]};
  // The top bit of the trial is set only when the subtraction went negative.
  assign trial   = shifted - {1'b0, divisor_i};

  assign rem_o  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quot_o = {quot_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider producing one quotient bit per cycle (restoring division).
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-high reset
//   start       - divide request, accepted only in the idle or done state
//   div_in1     - dividend, sampled with an accepted start
//   div_in2     - divisor, sampled with an accepted start
//   busy        - high while a divide is iterating
//   done        - one-cycle pulse when new results are presented
//   div_quot    - quotient, held until the next result
//   div_rem     - remainder, held until the next result
//   div_by_zero - set with done when the divisor was zero
module seq_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] div_in1,
  input  logic [WIDTH-1:0] div_in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  // Sign-extending the package constant yields all ones at any width.
  localparam logic [WIDTH-1:0] AllOnes = WIDTH'(signed'(DbzQuot));

  state_e state_q, state_d;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quot;
  logic             accept;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = (div_in2 != '0) ? StRun : StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Datapath next-state.
  always_comb begin
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
    if (accept) begin
      quot_d = div_in1;
      dvsr_d = div_in2;
      rem_d  = '0;
      cnt_d  = CntW'(WIDTH - 1);
      dbz_d  = 1'b0;
      if (div_in2 == '0) begin
        // Zero divisor skips the iteration and publishes its result right away.
        quot_out_d = AllOnes;
        rem_out_d  = div_in1;
        dbz_d      = 1'b1;
      end
    end else if (state_q == StRun) begin
      rem_d  = step_rem;
      quot_d = step_quot;
      cnt_d  = cnt_q - CntW'(1);
      // Results are published only on the final step so RUN values never leak out.
      if (cnt_q == '0) begin
        quot_out_d = step_quot;
        rem_out_d  = step_rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign div_quot    = quot_out_q;
  assign div_rem     = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative 32-bit unsigned divider, the subtraction-based counterpart of the combinational adder. It computes quotient and remainder by restoring division, producing one quotient bit per cycle. It sits beside the ALU as a multi-cycle functional unit. A start/busy/done handshake lets the pipeline stall while a divide is in flight.

## Interface
- WIDTH, 32, operand and result width in bits
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a divide; sampled only when the unit is idle (IDLE or DONE state)
- div_in1  input  WIDTH  dividend, unsigned; sampled with start
- div_in2  input  WIDTH  divisor, unsigned; sampled with start
- busy  output  1  high while a divide is in progress
- done  output  1  one-cycle pulse; results valid from this cycle onward
- div_quot  output  WIDTH  quotient; held until the next accepted start
- div_rem  output  WIDTH  remainder; held until the next accepted start
- div_by_zero  output  1  set with done when the divisor was 0; held like the results

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch dividend into the quotient shift register, divisor into a divisor register, and clear the partial remainder.
  - Set counter = WIDTH-1.
  - Go to RUN if divisor≠0, otherwise go to DONE with the divide-by-zero result.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - Form {rem,quot} shifted left by 1.
  - trial = rem_shifted − divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial[WIDTH-1:0] and quot LSB = 1. Otherwise keep rem_shifted and set quot LSB = 0.
  - Counter decrements. When counter = 0, go to DONE.
- DONE:
  - Hold for one cycle, then go to IDLE.
  - A start sampled in DONE is accepted exactly as in IDLE (back-to-back divides).
- Divide by zero: div_quot = all ones, div_rem = dividend, div_by_zero = 1.
- A start while in RUN is ignored; the operands are not re-latched.
- Arithmetic is unsigned only. The remainder is always < divisor for a nonzero divisor, and no overflow is possible.

## Timing
- Reset values: state = IDLE; busy, done, div_by_zero = 0; div_quot, div_rem = 0.
- Normal latency: start sampled at edge N. busy is high for cycles N+1 through N+WIDTH (32 RUN cycles). At edge N+WIDTH+1, done = 1 with results valid, and busy = 0 in that cycle.
- Divide-by-zero latency: start at edge N, then done and div_by_zero at N+1. busy is never asserted.
- busy and done are never high together.
- div_quot and div_rem change only at the edge that raises done.
- Intermediate RUN values are not visible on the outputs, which hold the previous results.
- div_by_zero clears at the edge that accepts the next start.
- rst asserted at any point, including mid-RUN: at the next edge the block returns to the reset values above. The in-flight divide is discarded and no done is produced.
- rst and start in the same cycle: reset wins and the start is dropped.

## Structure
- Shared package divider_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH;
  - the all-ones divide-by-zero quotient constant.
- One sub-module is natural: div_step.
  - Combinational single-bit restoring step.
  - Inputs: rem, quot, divisor. Outputs: next rem, next quot.
  - Instantiated once inside the RUN datapath.
- The top level holds the FSM, the counter (5 bits for WIDTH=32, i.e. $clog2(WIDTH)), and the output registers.

## Test plan
- 7 ÷ 2, start at cycle 0: busy for cycles 1–32, done at cycle 33 with div_quot = 3, div_rem = 1, div_by_zero = 0.
- 10500000 ÷ 10: div_quot = 1050000, div_rem = 0. Then 0xFFFFFFFF ÷ 1: div_quot = 0xFFFFFFFF, div_rem = 0.
- 5 ÷ 0: done at cycle 1, div_by_zero = 1, div_quot = 0xFFFFFFFF, div_rem = 5, busy never high.
- Start 100 ÷ 7, then pulse start with 9 ÷ 3 at cycle 10: the second request is ignored. Result is 14 r 2 at cycle 33.
- Assert rst at cycle 15 of a divide: next cycle busy = 0 and all outputs = 0. No done pulse follows. A fresh 3 ÷ 5 then yields 0 r 3.
- Back-to-back: start held high through a DONE cycle, accepting 20 ÷ 6 immediately after 7 ÷ 2. Second done arrives 33 cycles after the first with 3 r 2.
